// File: rtl/ps2_kbd_rx.sv
// Host-side PS/2 keyboard receiver: line conditioning, 11-bit frame deserialiser,
// and 0xE0/0xF0 prefix folding into per-key make/break events.
module ps2_kbd_rx #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       key_valid
);

    localparam int FL_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic            clk_s1, clk_s2, data_s1, data_s2;
    logic            clk_filt, clk_filt_d;
    logic [FL_W-1:0] filt_cnt;
    logic            fall;

    state_t          state, state_d;
    logic [2:0]      bit_cnt, bit_cnt_d;
    logic [7:0]      shift, shift_d;
    logic            par_ok, par_ok_d;
    logic [TO_W-1:0] to_cnt, to_cnt_d;
    logic            done_ok, done_err;
    logic            ext_pend, brk_pend;

    // Two-flop synchronisers, then a run-length filter on the clock line.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            data_s1    <= 1'b1;
            data_s2    <= 1'b1;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_s1     <= ps2_clk;
            clk_s2     <= clk_s1;
            data_s1    <= ps2_data;
            data_s2    <= data_s1;
            clk_filt_d <= clk_filt;
            if (clk_s2 != clk_filt) begin
                if (filt_cnt == FL_W'(FILTER_LEN - 1)) begin
                    clk_filt <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall = clk_filt_d & ~clk_filt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par_ok  <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            shift   <= shift_d;
            par_ok  <= par_ok_d;
            to_cnt  <= to_cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        par_ok_d  = par_ok;
        to_cnt_d  = to_cnt;
        done_ok   = 1'b0;
        done_err  = 1'b0;

        if (state != IDLE) to_cnt_d = to_cnt + 1'b1;
        if (fall)          to_cnt_d = '0;

        case (state)
            IDLE: begin
                if (fall && !data_s2) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {data_s2, shift[7:1]};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_ok_d = ^{shift, data_s2};
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    if (data_s2 && par_ok) done_ok  = 1'b1;
                    else                   done_err = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled frame is abandoned; a fall in the same cycle still wins.
        if (state != IDLE && !fall && to_cnt == TO_W'(TIMEOUT - 1)) begin
            state_d  = IDLE;
            to_cnt_d = '0;
            done_err = 1'b1;
        end
    end

    // rx_valid, frame_err and key_valid are single-cycle pulses with no back-pressure;
    // the data outputs hold their last value between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            key_code  <= '0;
            key_break <= 1'b0;
            key_ext   <= 1'b0;
            key_valid <= 1'b0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
        end else begin
            rx_valid  <= done_ok;
            frame_err <= done_err;
            key_valid <= 1'b0;
            if (done_ok) begin
                rx_byte <= shift;
                if (shift == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    key_valid <= 1'b1;
                    key_code  <= shift;
                    key_break <= brk_pend;
                    key_ext   <= ext_pend;
                    ext_pend  <= 1'b0;
                    brk_pend  <= 1'b0;
                end
            end
            if (done_err) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: table of frames with hand-derived key events, plus
// glitch, timeout and mid-frame reset sequences.
module tb_ps2_kbd_rx;
    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 5000;
    localparam int W          = 21;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic       key_valid;

    always #5 clk = ~clk;

    ps2_kbd_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err),
        .key_code(key_code), .key_break(key_break), .key_ext(key_ext),
        .key_valid(key_valid)
    );

    typedef struct {
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        bit         exp_err;
        bit         exp_key;
        bit         exp_brk;
        bit         exp_ext;
    } vec_t;

    vec_t       vecs[16];
    logic [W-1:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         ev_cnt  = 0;
    logic [W-1:0] mon_act, mon_exp;

    // Event word: {err, rx_valid, key_valid, brk, ext, key_code, rx_byte}
    function automatic logic [W-1:0] mk_ev(input bit err, input bit rxv, input bit kv,
                                           input bit brk, input bit ext,
                                           input logic [7:0] kc, input logic [7:0] rb);
        return {err, rxv, kv, brk, ext, kc, rb};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && (rx_valid || frame_err || key_valid)) begin
            ev_cnt++;
            mon_act = mk_ev(frame_err, rx_valid, key_valid,
                            key_valid ? key_break : 1'b0, key_valid ? key_ext : 1'b0,
                            key_valid ? key_code : 8'h00, rx_valid ? rx_byte : 8'h00);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'(mon_act), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("event", 32'(mon_act), 32'(mon_exp));
            end
            chk("valid_err_exclusive", 32'(rx_valid & frame_err), 32'd0);
        end
    end

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input int nbits);
        logic [10:0] fr;
        int hp;
        int k;
        fr = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        hp = $urandom_range(30, 60);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            repeat (hp) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                for (k = 1; k <= hp; k++) begin
                    @(negedge clk);
                    if (rx_valid || frame_err) break;
                end
                chk("latency", 32'(k), 32'd7);
                if (k < hp) repeat (hp - k) @(negedge clk);
            end else begin
                repeat (hp) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int saved;
        int t;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_rx_byte",   32'(rx_byte),   32'd0);
        chk("reset_rx_valid",  32'(rx_valid),  32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_key_code",  32'(key_code),  32'd0);
        chk("reset_key_break", 32'(key_break), 32'd0);
        chk("reset_key_ext",   32'(key_ext),   32'd0);
        chk("reset_key_valid", 32'(key_valid), 32'd0);

        vecs[0]  = '{8'h29, 0, 0, 0, 1, 0, 0};
        vecs[1]  = '{8'hF0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{8'h1B, 0, 0, 0, 1, 1, 0};
        vecs[3]  = '{8'hE0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{8'hF0, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{8'h75, 0, 0, 0, 1, 1, 1};
        vecs[6]  = '{8'h5A, 0, 0, 0, 1, 0, 0};
        vecs[7]  = '{8'hF0, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{8'h5A, 1, 0, 1, 0, 0, 0};
        vecs[9]  = '{8'h1D, 0, 0, 0, 1, 0, 0};
        vecs[10] = '{8'hF0, 0, 0, 0, 0, 0, 0};
        vecs[11] = '{8'hF0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{8'h1B, 0, 0, 0, 1, 1, 0};
        vecs[13] = '{8'hE0, 0, 0, 0, 0, 0, 0};
        vecs[14] = '{8'h12, 0, 1, 1, 0, 0, 0};
        vecs[15] = '{8'h6B, 0, 0, 0, 1, 0, 0};

        for (int v = 0; v < 16; v++) begin
            if (vecs[v].exp_err)
                exp_q.push_back(mk_ev(1, 0, 0, 0, 0, 8'h00, 8'h00));
            else if (vecs[v].exp_key)
                exp_q.push_back(mk_ev(0, 1, 1, vecs[v].exp_brk, vecs[v].exp_ext,
                                      vecs[v].data, vecs[v].data));
            else
                exp_q.push_back(mk_ev(0, 1, 0, 0, 0, 8'h00, vecs[v].data));
            send_frame(vecs[v].data, vecs[v].bad_par, vecs[v].bad_stop, 11);
            wait_drain();
        end

        repeat (20) @(negedge clk);
        chk("hold_key_code", 32'(key_code), 32'h6B);
        chk("hold_rx_byte",  32'(rx_byte),  32'h6B);
        chk("hold_key_ext",  32'(key_ext),  32'd0);

        // Short low glitch with data low: must not start a frame.
        saved = ev_cnt;
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        ps2_data = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_no_event", 32'(ev_cnt), 32'(saved));

        // Break prefix, then a stalled frame: timeout must clear the pending break.
        exp_q.push_back(mk_ev(0, 1, 0, 0, 0, 8'h00, 8'hF0));
        send_frame(8'hF0, 0, 0, 11);
        wait_drain();
        exp_q.push_back(mk_ev(1, 0, 0, 0, 0, 8'h00, 8'h00));
        send_frame(8'h5A, 0, 0, 4);
        for (t = 1; t <= 6000; t++) begin
            @(negedge clk);
            if (frame_err) break;
        end
        chk("timeout_window", 32'(t >= TIMEOUT - 70 && t <= TIMEOUT), 32'd1);
        wait_drain();
        exp_q.push_back(mk_ev(0, 1, 1, 0, 0, 8'h1D, 8'h1D));
        send_frame(8'h1D, 0, 0, 11);
        wait_drain();

        // Reset after five data bits of a frame, with a break pending.
        exp_q.push_back(mk_ev(0, 1, 0, 0, 0, 8'h00, 8'hF0));
        send_frame(8'hF0, 0, 0, 11);
        wait_drain();
        send_frame(8'h55, 0, 0, 6);
        saved = ev_cnt;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("midreset_no_event", 32'(ev_cnt), 32'(saved));
        chk("midreset_key_code", 32'(key_code), 32'd0);
        exp_q.push_back(mk_ev(0, 1, 1, 0, 0, 8'h23, 8'h23));
        send_frame(8'h23, 0, 0, 11);
        wait_drain();
        chk("final_key_code", 32'(key_code), 32'h23);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
